// File: rtl/verlet_step_sequencer.sv
// rtl/verlet_step_sequencer.sv - sequences one Verlet integrate step plus chain-length constraint passes
// Every output is registered; x/y positions arrive through an external mux steered by node_sel.
module verlet_step_sequencer #(
  parameter int          N_NODES  = 8,
  parameter int          ITERS    = 2,
  parameter logic [31:0] MAX_D    = 32'h00014000,
  parameter logic [31:0] ANCHOR_X = 32'h00190000,
  parameter logic [31:0] ANCHOR_Y = 32'h00000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_NODES-1:0] node_finish,
  input  logic [31:0]        node_x_in,
  input  logic [31:0]        node_y_in,
  output logic               verlet_state,
  output logic [N_NODES-1:0] fix_constraint_state,
  output logic [31:0]        x_fix,
  output logic [31:0]        y_fix,
  output logic [7:0]         node_sel,
  output logic               busy,
  output logic               step_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VERLET = 3'd1;
  localparam logic [2:0] WAIT_V = 3'd2;
  localparam logic [2:0] FIX_RD = 3'd3;
  localparam logic [2:0] FIX_WR = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic [7:0] LAST_IDX  = 8'(N_NODES - 1);
  localparam logic [3:0] LAST_ITER = 4'(ITERS - 1);

  logic [2:0]  state;
  logic [7:0]  idx;
  logic [3:0]  iter;
  logic [31:0] prev_x;
  logic [31:0] prev_y;
  logic [31:0] corr_x;
  logic [31:0] corr_y;

  // The difference wraps modulo 2^32 and is then read as signed; a gap of exactly MAX_D is legal.
  function automatic logic [31:0] limit_axis(input logic [31:0] pos, input logic [31:0] prev);
    logic signed [31:0] d;
    d = $signed(pos - prev);
    if (d > $signed(MAX_D)) begin
      return prev + MAX_D;
    end else if (d < -$signed(MAX_D)) begin
      return prev - MAX_D;
    end
    return pos;
  endfunction

  assign corr_x = (idx == 8'd0) ? ANCHOR_X : limit_axis(node_x_in, prev_x);
  assign corr_y = (idx == 8'd0) ? ANCHOR_Y : limit_axis(node_y_in, prev_y);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      verlet_state         <= 1'b0;
      fix_constraint_state <= '0;
      x_fix                <= 32'd0;
      y_fix                <= 32'd0;
      node_sel             <= 8'd0;
      busy                 <= 1'b0;
      step_done            <= 1'b0;
      idx                  <= 8'd0;
      iter                 <= 4'd0;
      prev_x               <= 32'd0;
      prev_y               <= 32'd0;
    end else begin
      verlet_state         <= 1'b0;
      step_done            <= 1'b0;
      fix_constraint_state <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= VERLET;
            verlet_state <= 1'b1;
            busy         <= 1'b1;
          end
        end
        VERLET: state <= WAIT_V;
        WAIT_V: begin
          if (&node_finish) begin
            state    <= FIX_RD;
            idx      <= 8'd0;
            iter     <= 4'd0;
            node_sel <= 8'd0;
          end
        end
        FIX_RD: begin
          x_fix                <= corr_x;
          y_fix                <= corr_y;
          prev_x               <= corr_x;
          prev_y               <= corr_y;
          fix_constraint_state <= N_NODES'(1) << idx;
          state                <= FIX_WR;
        end
        FIX_WR: begin
          if (idx == LAST_IDX) begin
            idx <= 8'd0;
            if (iter < LAST_ITER) begin
              iter     <= iter + 4'd1;
              node_sel <= 8'd0;
              state    <= FIX_RD;
            end else begin
              // step_done rises with busy falling, so the DONE cycle itself is not busy
              state     <= DONE;
              step_done <= 1'b1;
              busy      <= 1'b0;
            end
          end else begin
            idx      <= idx + 8'd1;
            node_sel <= idx + 8'd1;
            state    <= FIX_RD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
